// File: rtl/sram_pkg.sv
// sram_pkg: shared state type and address-width helper for the sram_array block.
package sram_pkg;

    typedef enum logic {CLEAR, READY} state_e;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// sram_clear_ctrl: post-reset clear sequencer; walks every word once and owns busy.
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          busy_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = (state_q == CLEAR && ptr_q == LAST) ? READY : state_q;
        ptr_d   = (state_q == CLEAR) ? ptr_q + 1'b1 : ptr_q;
        busy_d  = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // The reset edge itself must leave the array untouched.
    assign clr_we_o   = (state_q == CLEAR) && !rst;
    assign clr_addr_o = ptr_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/sram_array.sv
// sram_array: DEPTH x WIDTH storage with one write port, one registered read port
// and an automatic zero-fill after every reset.
module sram_array
    import sram_pkg::*;
#(
    parameter int  WIDTH       = 8,
    parameter int  DEPTH       = 16,
    parameter int  WRITE_FIRST = 1,
    localparam int AW          = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d, wr_data;
    logic             rvalid_q, rvalid_d;
    logic             clr_we, usr_we, wr_en, rd_ok;
    logic [AW-1:0]    clr_addr, wr_addr;

    sram_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    always_comb begin
        usr_we   = we && ({1'b0, waddr} < DEPTH_W);
        rd_ok    = {1'b0, raddr} < DEPTH_W;
        wr_en    = busy ? clr_we : usr_we;
        wr_addr  = busy ? clr_addr : waddr;
        wr_data  = busy ? '0 : wdata;
        rvalid_d = re && !busy;
        // Collision bypass only matters for an in-range write to the read address.
        rdata_d  = !rvalid_d ? rdata_q :
                   !rd_ok ? '0 :
                   (WRITE_FIRST != 0 && usr_we && waddr == raddr) ? wdata : mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_sram_array.sv
// tb_sram_array: three configurations (16/write-first, 16/read-first, 12/write-first)
// driven in lockstep and checked against a word-array reference model.
module tb_sram_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0, re = 1'b0;
    logic [3:0] waddr = '0, raddr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rd [3];
    logic       rv [3];
    logic       bz [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_array #(.WIDTH(8), .DEPTH(16), .WRITE_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rd[0]), .rvalid(rv[0]), .busy(bz[0]));
    sram_array #(.WIDTH(8), .DEPTH(16), .WRITE_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rd[1]), .rvalid(rv[1]), .busy(bz[1]));
    sram_array #(.WIDTH(8), .DEPTH(12), .WRITE_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rd[2]), .rvalid(rv[2]), .busy(bz[2]));

    // Reference model: remaining clear edges, word array, expected outputs.
    int         dep [3] = '{16, 16, 12};
    int         wfp [3] = '{1, 0, 1};
    int         cnt [3];
    logic [7:0] mmem [3][16];
    logic [7:0] mrd [3];
    logic       mrv [3];
    bit         live = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                cnt[k] = dep[k];
                mrd[k] = 8'h00;
                mrv[k] = 1'b0;
                live   = 1'b1;
            end else if (cnt[k] > 0) begin
                mmem[k][dep[k] - cnt[k]] = 8'h00;
                cnt[k] = cnt[k] - 1;
                mrv[k] = 1'b0;
            end else begin
                mrv[k] = re;
                if (re) begin
                    if (int'(raddr) >= dep[k]) mrd[k] = 8'h00;
                    else if (we && waddr == raddr && wfp[k] == 1) mrd[k] = wdata;
                    else mrd[k] = mmem[k][raddr];
                end
                if (we && int'(waddr) < dep[k]) mmem[k][waddr] = wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(cnt[k] > 0));
                chk($sformatf("rvalid[%0d]", k), 32'(rv[k]), 32'(mrv[k]));
                chk($sformatf("rdata[%0d]", k), 32'(rd[k]), 32'(mrd[k]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        we = 1'b1; re = 1'b0; waddr = a; wdata = d;
        tick;
        we = 1'b0;
    endtask

    task automatic rdx(input logic [3:0] a);
        re = 1'b1; raddr = a;
        tick;
        re = 1'b0;
    endtask

    // Counts edges with rst low until busy drops, hammering we/re meanwhile.
    task automatic clear_wait(output int na, output int nc);
        na = 0;
        nc = 0;
        do begin
            we    = 1'($urandom_range(0, 1));
            re    = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            raddr = 4'($urandom_range(0, 15));
            wdata = 8'($urandom);
            tick;
            na++;
            if (nc == 0 && !bz[2]) nc = na;
        end while (bz[0] && na < 100);
        we = 1'b0;
        re = 1'b0;
    endtask

    int na, nc;

    initial begin
        tick;
        chk("reset_busy", 32'(bz[0]), 32'd1);
        chk("reset_rvalid", 32'(rv[0]), 32'd0);
        chk("reset_rdata", 32'(rd[0]), 32'd0);
        tick;
        rst = 1'b0;
        clear_wait(na, nc);
        chk("busy_len_16", 32'(na), 32'd16);
        chk("busy_len_12", 32'(nc), 32'd12);
        for (int a = 0; a < 16; a++) begin
            rdx(4'(a));
            chk("cleared_word", 32'(rd[0]), 32'h00);
            chk("cleared_rvalid", 32'(rv[0]), 32'd1);
        end
        wr(4'd3, 8'hA5);
        wr(4'd15, 8'h5A);
        re = 1'b1; raddr = 4'd3;
        tick;
        chk("read3", 32'(rd[0]), 32'hA5);
        raddr = 4'd15;
        tick;
        chk("read15", 32'(rd[0]), 32'h5A);
        chk("read15_rvalid", 32'(rv[0]), 32'd1);
        chk("read15_oor_c", 32'(rd[2]), 32'h00);
        re = 1'b0;
        wr(4'd7, 8'h11);
        we = 1'b1; re = 1'b1; waddr = 4'd7; raddr = 4'd7; wdata = 8'h22;
        tick;
        chk("coll_write_first", 32'(rd[0]), 32'h22);
        chk("coll_read_first", 32'(rd[1]), 32'h11);
        we = 1'b0;
        tick;
        chk("coll_after_a", 32'(rd[0]), 32'h22);
        chk("coll_after_b", 32'(rd[1]), 32'h22);
        re = 1'b0;
        wr(4'd13, 8'hFF);
        rdx(4'd13);
        chk("oor_read_c", 32'(rd[2]), 32'h00);
        chk("oor_rvalid_c", 32'(rv[2]), 32'd1);
        chk("inrange13_a", 32'(rd[0]), 32'hFF);
        repeat (500) begin
            we    = 1'($urandom_range(0, 1));
            re    = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            wdata = 8'($urandom);
            tick;
        end
        we = 1'b0; re = 1'b0;
        wr(4'd2, 8'h3C);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (5) tick;
        chk("midclear_busy", 32'(bz[0]), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_wait(na, nc);
        chk("reclear_len_16", 32'(na), 32'd16);
        chk("reclear_len_12", 32'(nc), 32'd12);
        rdx(4'd2);
        chk("reclear_word2", 32'(rd[0]), 32'h00);
        chk("reclear_rvalid", 32'(rv[0]), 32'd1);
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_array.md
# sram_array

Parametrised, clocked word-addressable storage array: the successor to the single gated-latch bit cell. It provides DEPTH words of WIDTH bits with one write port and one registered read port. After reset, a built-in clear sequencer zeroes every word. The block is the storage core behind the project's memory controller and is also used stand-alone for cell/array characterisation benches.

## Interface
Parameters:
- WIDTH, 8: bits per word.
- DEPTH, 16: number of words, ≥ 2; need not be a power of two.
- AW, $clog2(DEPTH): address width (derived, not overridden).
- WRITE_FIRST, 1: same-address read/write collision policy (1 = new data, 0 = old data).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- re  in  1  read enable.
- raddr  in  AW  read address.
- rdata  out  WIDTH  registered read data.
- rvalid  out  1  one-cycle pulse; rdata updated this cycle.
- busy  out  1  clear sequence in progress; accesses ignored.

## Operation
- States: CLEAR, READY.
- Reset (rst=1 at an edge): state←CLEAR, clear pointer←0, rdata←0, rvalid←0, busy←1. Array contents are not touched by the reset edge itself.
- CLEAR: each edge with rst=0 writes 0 to mem[ptr] and increments ptr. At ptr==DEPTH-1, that word is cleared and state←READY.
  - The sequence takes exactly DEPTH edges after rst deasserts.
  - we/re are ignored; rvalid stays 0.
- READY:
  - we=1 and waddr<DEPTH: mem[waddr]←wdata at the edge.
  - re=1: rdata←mem[raddr] at the edge and rvalid←1 for exactly that following cycle.
  - re=0: rvalid←0 and rdata holds its last value.
- Collision (we & re, waddr==raddr, in range): WRITE_FIRST=1 gives rdata=wdata; WRITE_FIRST=0 gives rdata=previous contents. The array is written in both cases.
- Out of range (address ≥ DEPTH):
  - A write is dropped.
  - A read returns rdata=0 with rvalid=1.
- Reset mid-CLEAR or mid-READY: immediate return to CLEAR with ptr=0, and a full re-clear follows.

## Timing
- Read latency: 1 cycle (re sampled at edge N, rdata/rvalid valid after edge N, during cycle N+1).
- Write visibility: a read issued in a cycle after the write edge sees the new data. A same-cycle read follows WRITE_FIRST.
- Back-to-back reads every cycle are allowed: rvalid stays high and rdata changes each cycle.
- busy: 1 from the reset edge through the last CLEAR edge; 0 from the first READY cycle. Post-reset latency to the first accepted access is DEPTH cycles.
- Output reset values: rdata=0, rvalid=0, busy=1.

## Structure
- Shared package sram_pkg:
  - state typedef (CLEAR, READY);
  - a localparam function for AW derivation.
- Sub-module sram_clear_ctrl holds the state register, the clear pointer and busy. It drives the clear-write address/enable into the array write mux.
- Storage is a plain reg array inside sram_array. The write mux selects between the clear path and the user path on busy.

## Test plan
- Reset, then hold rst=0 for 16 cycles (DEPTH=16) → busy=1 for exactly 16 cycles. Then read all addresses → rdata=0x00 with rvalid=1 each.
- Write 0xA5@3 and 0x5A@15, then read 3 and 15 on consecutive cycles → rdata 0xA5 then 0x5A, one cycle after each re, with rvalid continuously high.
- Same-cycle we/re at addr 7 with old=0x11, wdata=0x22 → rdata=0x22 with WRITE_FIRST=1; rdata=0x11 with WRITE_FIRST=0. mem[7]=0x22 in both cases.
- DEPTH=12:
  - write 0xFF@13 → dropped, all words unchanged;
  - read @13 → rdata=0, rvalid=1.
- Write 0x3C@2, then pulse rst mid-CLEAR at cycle 5 of clear → busy restarts and lasts 16 more cycles; afterwards a read of 2 returns 0x00.
- Assert we/re while busy → no writes land, rvalid stays 0, rdata stays 0.
